// File: rtl/alu_result_skid.sv
// Two-entry registered skid buffer between the ALU result path and write-back.
// Main register drives the outputs; the skid register absorbs one result under backpressure.
module alu_result_skid #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [TAG_W-1:0]  in_rd,
  input  logic              in_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_rd,
  output logic              out_wen,
  output logic              out_zero
);

  // State bits are {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t r_state, w_state_nx;
  logic   r_in_ready;

  logic [DATA_W-1:0] r_m_result, r_s_result;
  logic [TAG_W-1:0]  r_m_rd, r_s_rd;
  logic              r_m_wen, r_s_wen;
  logic              r_m_zero, r_s_zero;

  logic w_accept, w_pop, w_in_zero;
  logic w_ld_main_in, w_ld_main_skid, w_ld_skid;

  assign w_accept  = in_valid & r_in_ready;
  assign w_pop     = r_state[1] & out_ready;
  assign w_in_zero = (in_result == '0);

  always_comb begin
    w_state_nx     = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nx = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_ld_main_in = 1'b1;
            w_state_nx   = ONE;
          end
        end
        ONE: begin
          if (w_accept && w_pop) begin
            w_ld_main_in = 1'b1;
          end else if (w_accept) begin
            w_ld_skid  = 1'b1;
            w_state_nx = FULL;
          end else if (w_pop) begin
            w_state_nx = EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_ld_main_skid = 1'b1;
            w_state_nx     = ONE;
          end
        end
        default: w_state_nx = EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_in_ready <= (w_state_nx != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_result <= '0;
      r_m_rd     <= '0;
      r_m_wen    <= 1'b0;
      r_m_zero   <= 1'b0;
      r_s_result <= '0;
      r_s_rd     <= '0;
      r_s_wen    <= 1'b0;
      r_s_zero   <= 1'b0;
    end else begin
      if (w_ld_main_in) begin
        r_m_result <= in_result;
        r_m_rd     <= in_rd;
        r_m_wen    <= in_wen;
        r_m_zero   <= w_in_zero;
      end else if (w_ld_main_skid) begin
        r_m_result <= r_s_result;
        r_m_rd     <= r_s_rd;
        r_m_wen    <= r_s_wen;
        r_m_zero   <= r_s_zero;
      end
      if (w_ld_skid) begin
        r_s_result <= in_result;
        r_s_rd     <= in_rd;
        r_s_wen    <= in_wen;
        r_s_zero   <= w_in_zero;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_state[1];
  assign out_result = r_m_result;
  assign out_rd     = r_m_rd;
  assign out_wen    = r_m_wen;
  assign out_zero   = r_m_zero;

endmodule
